// File: rtl/zone_color_avg.sv
// Zone colour averager: sums R/G/B over one rectangular zone of each video frame,
// divides by the pixel count, optionally IIR-smooths, and pulses trig per frame.
module zone_color_avg #(
  parameter int X_START = 16,
  parameter int Y_START = 16,
  parameter int LOG2_W  = 4,
  parameter int LOG2_H  = 4,
  parameter int SMOOTH  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic       pix_sof,
  input  logic       pix_eol,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       trig
);

  localparam int          ACC_W   = 8 + LOG2_W + LOG2_H;
  localparam logic [15:0] X_FIRST = 16'(X_START);
  localparam logic [15:0] Y_FIRST = 16'(Y_START);
  localparam logic [15:0] X_LAST  = 16'(X_START + (1 << LOG2_W) - 1);
  localparam logic [15:0] Y_LAST  = 16'(Y_START + (1 << LOG2_H) - 1);

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, UPDATE} state_t;

  state_t           state;
  logic [15:0]      x, y;
  logic [ACC_W-1:0] acc_r, acc_g, acc_b;
  logic [7:0]       avg_r, avg_g, avg_b;
  logic             update_pend;

  logic [15:0]      cur_x, cur_y;
  logic             in_zone, zone_last;
  logic [ACC_W-1:0] add_r, add_g, add_b;

  // A sof pixel is position (0,0) regardless of what the counters held.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    cur_x     = pix_sof ? 16'd0 : x;
    cur_y     = pix_sof ? 16'd0 : y;
    in_zone   = (cur_x >= X_FIRST) && (cur_x <= X_LAST) &&
                (cur_y >= Y_FIRST) && (cur_y <= Y_LAST);
    zone_last = (cur_x == X_LAST) && (cur_y == Y_LAST);
    add_r     = in_zone ? ACC_W'(pix_r) : '0;
    add_g     = in_zone ? ACC_W'(pix_g) : '0;
    add_b     = in_zone ? ACC_W'(pix_b) : '0;
  end

  // First-order IIR step on a 10-bit signed difference, clamped to the 8-bit range.
  function automatic logic [7:0] blend(input logic [7:0] cur, input logic [7:0] avg);
    logic signed [9:0] diff, step, nxt;
    if (SMOOTH == 0) return avg;
    diff = $signed({2'b00, avg}) - $signed({2'b00, cur});
    step = diff >>> SMOOTH;
    nxt  = $signed({2'b00, cur}) + step;
    if (nxt < 10'sd0)        return 8'h00;
    else if (nxt > 10'sd255) return 8'hFF;
    else                     return nxt[7:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_SOF;
      x           <= '0;
      y           <= '0;
      acc_r       <= '0;
      acc_g       <= '0;
      acc_b       <= '0;
      avg_r       <= '0;
      avg_g       <= '0;
      avg_b       <= '0;
      update_pend <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      trig        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below makes trig a single-cycle pulse.
      trig <= 1'b0;

      if (pix_valid) begin
        if (pix_eol) begin
          x <= '0;
          y <= sat_inc(cur_y);
        end else begin
          x <= sat_inc(cur_x);
          y <= cur_y;
        end

        case (state)
          WAIT_SOF, ACCUM: begin
            if (pix_sof) begin
              acc_r <= add_r;
              acc_g <= add_g;
              acc_b <= add_b;
              state <= zone_last ? UPDATE : ACCUM;
            end else if (state == ACCUM) begin
              acc_r <= acc_r + add_r;
              acc_g <= acc_g + add_g;
              acc_b <= acc_b + add_b;
              if (zone_last) state <= UPDATE;
            end
          end
          default: ;
        endcase
      end

      // Divide by the zone size: the top 8 bits of each accumulator.
      if (state == UPDATE) begin
        avg_r       <= acc_r[ACC_W-1 -: 8];
        avg_g       <= acc_g[ACC_W-1 -: 8];
        avg_b       <= acc_b[ACC_W-1 -: 8];
        update_pend <= 1'b1;
        state       <= WAIT_SOF;
      end

      if (update_pend) begin
        red         <= blend(red,   avg_r);
        green       <= blend(green, avg_g);
        blue        <= blend(blue,  avg_b);
        trig        <= 1'b1;
        update_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zone_color_avg.sv
// Bench for zone_color_avg: 4x2 zone at (2,1) inside a 6x3 frame; SMOOTH=0 and SMOOTH=1 instances.
module tb_zone_color_avg;

  localparam int FW = 6;
  localparam int FH = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid, pix_sof, pix_eol;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [7:0] red0, green0, blue0, red1, green1, blue1;
  logic       trig0, trig1;

  zone_color_avg #(.X_START(2), .Y_START(1), .LOG2_W(2), .LOG2_H(1), .SMOOTH(0)) u_dut0 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red(red0), .green(green0), .blue(blue0), .trig(trig0));

  zone_color_avg #(.X_START(2), .Y_START(1), .LOG2_W(2), .LOG2_H(1), .SMOOTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red(red1), .green(green1), .blue(blue1), .trig(trig1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r, g, b;
    int         edge_n;
  } exp_t;

  typedef struct {
    int         kind;   // 0 uniform, 1 red ramp in zone, 2 mixed pattern in zone
    logic [7:0] r, g, b;
    bit         gaps;
    logic [7:0] er, eg, eb;
  } frame_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   trig0_cnt = 0;
  int   push_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every trig must match a pushed frame, with fixed latency.
  always @(negedge clk) begin
    if (trig0 === 1'b1) begin
      trig0_cnt++;
      check("trig_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("trig_latency", cyc, e.edge_n + 2);
        check("red",   red0,   e.r);
        check("green", green0, e.g);
        check("blue",  blue0,  e.b);
      end
    end
  end

  task automatic pixel_value(input frame_t f, input int x, input int y,
                             output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    bit zone;
    zone = (x >= 2) && (x <= 5) && (y >= 1) && (y <= 2);
    r = f.r; g = f.g; b = f.b;
    if (f.kind != 0 && !zone) begin
      r = 8'hFF; g = 8'hFF; b = 8'hFF;
    end else if (f.kind == 1) begin
      r = 8'((y - 1) * 4 + (x - 2)); g = 8'h20; b = 8'h00;
    end else if (f.kind == 2) begin
      r = 8'h01; g = 8'(x * y); b = ((x + y) % 2 == 1) ? 8'hFF : 8'h00;
    end
  endtask

  task automatic send_pix(input bit sof, input bit eol, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input bit gaps, output int edge_n);
    if (gaps) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
        pix_valid = 1'b0;
        pix_sof = 1'($urandom); pix_eol = 1'($urandom);
        pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b1;
    pix_sof = sof; pix_eol = eol;
    pix_r = r; pix_g = g; pix_b = b;
    @(posedge clk); #1;
    edge_n = cyc;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_eol = 1'b0;
  endtask

  // Drives the first n_pix pixels of a frame; pushes the expectation when the zone end is sent.
  task automatic drive_frame(input frame_t f, input int n_pix, input bit push);
    logic [7:0] r, g, b;
    int e;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        if (y * FW + x < n_pix) begin
          pixel_value(f, x, y, r, g, b);
          send_pix(y == 0 && x == 0, x == FW - 1, r, g, b, f.gaps, e);
          if (push && x == 5 && y == 2) begin
            sb.push_back('{f.er, f.eg, f.eb, e});
            push_cnt++;
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  frame_t     tbl[4];
  frame_t     f;
  logic [7:0] smooth_exp[4];

  initial begin
    tbl[0] = '{0, 8'h40, 8'h80, 8'hFF, 1'b0, 8'h40, 8'h80, 8'hFF};
    tbl[1] = '{1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h03, 8'h20, 8'h00};
    tbl[2] = '{2, 8'h00, 8'h00, 8'h00, 1'b0, 8'h01, 8'h05, 8'h7F};
    tbl[3] = '{0, 8'h40, 8'h80, 8'hFF, 1'b1, 8'h40, 8'h80, 8'hFF};
    smooth_exp = '{8'h40, 8'h60, 8'h70, 8'h38};

    reset = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_red",   red0,   0);
    check("rst_green", green0, 0);
    check("rst_blue",  blue0,  0);
    check("rst_trig",  trig0,  0);
    check("rst_red1",  red1,   0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive_frame(tbl[i], FW * FH, 1'b1);
      wait_drain();
    end

    // Truncated frame: a new sof lands where pixel (3,1) would be.
    f = '{0, 8'hAA, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 8'h00};
    drive_frame(f, 9, 1'b0);
    f = '{0, 8'h10, 8'h10, 8'h10, 1'b0, 8'h10, 8'h10, 8'h10};
    drive_frame(f, FW * FH, 1'b1);
    wait_drain();

    // Reset after five zone pixels: outputs clear and no trig from the partial frame.
    f = '{0, 8'h55, 8'h55, 8'h55, 1'b0, 8'h00, 8'h00, 8'h00};
    drive_frame(f, 15, 1'b0);
    pulse_reset();
    check("midrst_red",   red0,   0);
    check("midrst_green", green0, 0);
    check("midrst_blue",  blue0,  0);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_trig", trig0_cnt, push_cnt);
    f = '{0, 8'h33, 8'h66, 8'h99, 1'b0, 8'h33, 8'h66, 8'h99};
    drive_frame(f, FW * FH, 1'b1);
    wait_drain();

    // IIR path on the SMOOTH=1 instance, starting from zero.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      f.kind = 0; f.gaps = 1'b0;
      f.r = (k < 3) ? 8'h80 : 8'h00;
      f.g = f.r; f.b = f.r;
      f.er = f.r; f.eg = f.r; f.eb = f.r;
      drive_frame(f, FW * FH, 1'b1);
      wait_drain();
      check($sformatf("smooth_red_%0d", k), red1, smooth_exp[k]);
      check($sformatf("smooth_blue_%0d", k), blue1, smooth_exp[k]);
    end

    check("trig_count", trig0_cnt, push_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
